// File: rtl/note_input_pkg.sv
// Shared note codes, load-FSM encodings and the key priority encoder,
// used by note_input and by the vga_data drawer.
package note_input_pkg;

    localparam logic [3:0] NOTE_NONE = 4'd0;
    localparam logic [3:0] NOTE_A    = 4'd1;
    localparam logic [3:0] NOTE_AS   = 4'd2;
    localparam logic [3:0] NOTE_B    = 4'd3;
    localparam logic [3:0] NOTE_C    = 4'd4;
    localparam logic [3:0] NOTE_CS   = 4'd5;
    localparam logic [3:0] NOTE_D    = 4'd6;
    localparam logic [3:0] NOTE_DS   = 4'd7;
    localparam logic [3:0] NOTE_E    = 4'd8;
    localparam logic [3:0] NOTE_F    = 4'd9;
    localparam logic [3:0] NOTE_FS   = 4'd10;
    localparam logic [3:0] NOTE_G    = 4'd11;
    localparam logic [3:0] NOTE_GS   = 4'd12;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Lowest-index pressed key wins; scanning downward lets it overwrite.
    function automatic logic [3:0] encode_note(input logic [11:0] keys);
        logic [3:0] code;
        code = NOTE_NONE;
        for (int i = 11; i >= 0; i--) begin
            if (keys[i]) begin
                code = NOTE_A + 4'(i);
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/note_input_debounce.sv
// Two-flop synchroniser followed by a stability counter for one raw button.
module debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Any reversion to the stable value restarts the count from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 != stable) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    stable <= sync2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/note_input.sv
// Debounced note keyboard with octave counter; hands the latest note/octave
// to the drawer with a held load strobe and a guard gap between loads.
module note_input
    import note_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int LD_HOLD         = 2,
    parameter int GAP_CYCLES      = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] key,
    input  logic        oct_up,
    input  logic        oct_down,
    output logic [3:0]  note,
    output logic [1:0]  octave,
    output logic        ld_note,
    output logic        note_active,
    output logic        busy
);
    localparam int CNT_MAX = (GAP_CYCLES > LD_HOLD) ? GAP_CYCLES : LD_HOLD;
    localparam int CW      = $clog2(CNT_MAX) + 1;

    logic [13:0]   raw_in;
    logic [13:0]   db;
    logic [11:0]   key_db;
    logic          up_db;
    logic          down_db;
    logic          up_prev;
    logic          down_prev;
    logic          up_rise;
    logic          down_rise;
    logic [1:0]    oct_cnt;
    logic [3:0]    code;
    logic          load_event;
    logic [1:0]    state;
    logic [CW-1:0] cnt;

    assign raw_in = {oct_down, oct_up, key};

    for (genvar g = 0; g < 14; g++) begin : g_db
        debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .reset  (reset),
            .raw    (raw_in[g]),
            .stable (db[g])
        );
    end

    assign key_db    = db[11:0];
    assign up_db     = db[12];
    assign down_db   = db[13];
    assign up_rise   = up_db & ~up_prev;
    assign down_rise = down_db & ~down_prev;

    // Coincident up/down edges cancel; both directions saturate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            up_prev   <= 1'b0;
            down_prev <= 1'b0;
            oct_cnt   <= 2'd0;
        end else begin
            up_prev   <= up_db;
            down_prev <= down_db;
            if (up_rise && !down_rise && oct_cnt != 2'd3) begin
                oct_cnt <= oct_cnt + 2'd1;
            end else if (down_rise && !up_rise && oct_cnt != 2'd0) begin
                oct_cnt <= oct_cnt - 2'd1;
            end
        end
    end

    // A release (code 0) never triggers a load; the last note is kept.
    assign code       = encode_note(key_db);
    assign load_event = ((code != NOTE_NONE) && (code != note)) || (oct_cnt != octave);

    assign note_active = |key_db;
    assign busy        = (state != ST_IDLE);

    // Events arriving in LOAD/GAP are not queued: IDLE simply re-compares
    // the live values, so bursts collapse to the most recent state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            note    <= NOTE_NONE;
            octave  <= 2'd0;
            ld_note <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_event) begin
                        if (code != NOTE_NONE) begin
                            note <= code;
                        end
                        octave  <= oct_cnt;
                        ld_note <= 1'b1;
                        cnt     <= '0;
                        state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (cnt == CW'(LD_HOLD - 1)) begin
                        ld_note <= 1'b0;
                        cnt     <= '0;
                        state   <= ST_GAP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt == CW'(GAP_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    ld_note <= 1'b0;
                    cnt     <= '0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_note_input.sv
// Directed and randomized bench for note_input with a cycle-level
// behavioural model built from the debounce/encode/load rules.
module tb_note_input;

    localparam int DEB  = 4;
    localparam int HOLD = 2;
    localparam int GAP  = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] key = '0;
    logic        oct_up = 1'b0;
    logic        oct_down = 1'b0;
    logic [3:0]  note;
    logic [1:0]  octave;
    logic        ld_note;
    logic        note_active;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;
    int ld_rises = 0;
    int ld_high_cnt = 0;
    int busy_cnt = 0;
    logic ld_prev = 1'b0;

    always #5 clk = ~clk;

    note_input #(
        .DEBOUNCE_CYCLES(DEB),
        .LD_HOLD        (HOLD),
        .GAP_CYCLES     (GAP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key         (key),
        .oct_up      (oct_up),
        .oct_down    (oct_down),
        .note        (note),
        .octave      (octave),
        .ld_note     (ld_note),
        .note_active (note_active),
        .busy        (busy)
    );

    // Reference model: raw inputs delayed two edges, accepted once the last
    // DEB samples agree and differ from the accepted value.
    logic [13:0] m_d1, m_d2, m_stab;
    logic [13:0] m_hist [DEB];
    logic [1:0]  m_prev;
    int m_oct_cnt, m_note, m_octave, m_ld_left, m_gap_left;

    always @(posedge clk or negedge reset) begin : model
        int code;
        bit evt, up_rise, dn_rise, same;
        logic [13:0] samp;
        if (!reset) begin
            m_d1 = '0; m_d2 = '0; m_stab = '0; m_prev = '0;
            for (int k = 0; k < DEB; k++) m_hist[k] = '0;
            m_oct_cnt = 0; m_note = 0; m_octave = 0;
            m_ld_left = 0; m_gap_left = 0;
        end else begin
            code = 0;
            for (int i = 0; i < 12; i++) begin
                if (m_stab[i] && code == 0) code = i + 1;
            end
            evt = (code != 0 && code != m_note) || (m_oct_cnt != m_octave);
            if (m_ld_left > 0) begin
                m_ld_left--;
                if (m_ld_left == 0) m_gap_left = GAP;
            end else if (m_gap_left > 0) begin
                m_gap_left--;
            end else if (evt) begin
                if (code != 0) m_note = code;
                m_octave = m_oct_cnt;
                m_ld_left = HOLD;
            end
            up_rise = m_stab[12] && !m_prev[0];
            dn_rise = m_stab[13] && !m_prev[1];
            if (up_rise && !dn_rise && m_oct_cnt < 3) m_oct_cnt++;
            if (dn_rise && !up_rise && m_oct_cnt > 0) m_oct_cnt--;
            m_prev = m_stab[13:12];
            samp = m_d2;
            for (int k = DEB - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = samp;
            for (int b = 0; b < 14; b++) begin
                same = 1'b1;
                for (int k = 0; k < DEB; k++) begin
                    if (m_hist[k][b] != samp[b]) same = 1'b0;
                end
                if (same && samp[b] != m_stab[b]) m_stab[b] = samp[b];
            end
            m_d2 = m_d1;
            m_d1 = {oct_down, oct_up, key};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        check("note", 32'(note), 32'(m_note));
        check("octave", 32'(octave), 32'(m_octave));
        check("ld_note", 32'(ld_note), 32'(m_ld_left > 0));
        check("note_active", 32'(note_active), 32'(|m_stab[11:0]));
        check("busy", 32'(busy), 32'((m_ld_left > 0) || (m_gap_left > 0)));
    endtask

    task automatic tick();
        @(negedge clk);
        check_output();
        if (ld_note === 1'b1 && !ld_prev) ld_rises++;
        if (ld_note === 1'b1) ld_high_cnt++;
        if (busy === 1'b1) busy_cnt++;
        ld_prev = ld_note;
    endtask

    task automatic apply_stimulus(input logic [11:0] k, input logic up, input logic dn, input int cycles);
        key = k;
        oct_up = up;
        oct_down = dn;
        repeat (cycles) tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        key = '0; oct_up = 1'b0; oct_down = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        ld_rises = 0; ld_high_cnt = 0; busy_cnt = 0; ld_prev = 1'b0;
    endtask

    task automatic wait_for_ld(input int max_cycles);
        int n = 0;
        while (ld_note !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        check("ld_timeout", 32'(ld_note), 32'd1);
    endtask

    initial begin : stim
        int exp_oct [6] = '{1, 2, 3, 3, 2, 1};
        logic [11:0] rk;
        int n;

        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_note", 32'(note), 32'd0);
        check("rst_octave", 32'(octave), 32'd0);
        check("rst_ld", 32'(ld_note), 32'd0);
        check("rst_active", 32'(note_active), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;

        // Single key press: one load of C with the full hold and gap.
        apply_stimulus(12'h008, 1'b0, 1'b0, 25);
        check("a_note", 32'(note), 32'd4);
        check("a_octave", 32'(octave), 32'd0);
        check("a_ld_cycles", 32'(ld_high_cnt), 32'd2);
        check("a_busy_cycles", 32'(busy_cnt), 32'd10);
        check("a_loads", 32'(ld_rises), 32'd1);
        apply_stimulus(12'h000, 1'b0, 1'b0, 10);

        // Three-cycle glitch is rejected.
        do_reset();
        apply_stimulus(12'h008, 1'b0, 1'b0, 3);
        apply_stimulus(12'h000, 1'b0, 1'b0, 20);
        check("b_loads", 32'(ld_rises), 32'd0);
        check("b_note", 32'(note), 32'd0);

        // Priority, then release is not an event.
        do_reset();
        apply_stimulus(12'h024, 1'b0, 1'b0, 20);
        check("c_note", 32'(note), 32'd3);
        apply_stimulus(12'h000, 1'b0, 1'b0, 20);
        check("c_loads", 32'(ld_rises), 32'd1);
        check("c_active", 32'(note_active), 32'd0);
        check("c_note_kept", 32'(note), 32'd3);

        // Octave walk with saturation, then coincident presses.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(12'h000, (i < 4), (i >= 4), 8);
            apply_stimulus(12'h000, 1'b0, 1'b0, 20);
            check($sformatf("d_octave%0d", i), 32'(octave), 32'(exp_oct[i]));
        end
        check("d_loads", 32'(ld_rises), 32'd5);
        apply_stimulus(12'h000, 1'b1, 1'b1, 8);
        apply_stimulus(12'h000, 1'b0, 1'b0, 20);
        check("d_both_octave", 32'(octave), 32'd1);
        check("d_both_loads", 32'(ld_rises), 32'd5);

        // Change during GAP is picked up right after the gap.
        do_reset();
        key = 12'h001;
        wait_for_ld(30);
        check("e_first_note", 32'(note), 32'd1);
        key = 12'h800;
        tick();
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        check("e_gap_end", 32'(busy), 32'd0);
        check("e_idle_ld", 32'(ld_note), 32'd0);
        tick();
        check("e_second_ld", 32'(ld_note), 32'd1);
        check("e_second_note", 32'(note), 32'd12);
        apply_stimulus(12'h000, 1'b0, 1'b0, 20);

        // Reset in the middle of LOAD.
        do_reset();
        key = 12'h008;
        wait_for_ld(30);
        key = 12'h000;
        reset = 1'b0;
        #1;
        check("f_ld", 32'(ld_note), 32'd0);
        check("f_note", 32'(note), 32'd0);
        check("f_octave", 32'(octave), 32'd0);
        check("f_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        ld_rises = 0; ld_prev = 1'b0;
        apply_stimulus(12'h000, 1'b0, 1'b0, 20);
        check("f_no_load", 32'(ld_rises), 32'd0);

        // Random patterns against the model.
        do_reset();
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 3))
                0: rk = '0;
                1: rk = 12'(1 << $urandom_range(0, 11));
                default: rk = 12'($urandom_range(0, 4095));
            endcase
            apply_stimulus(rk, ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                           $urandom_range(1, 14));
        end
        apply_stimulus(12'h000, 1'b0, 1'b0, 30);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
